pulpemu_rst_seq: RTL and testbench

PULPEMU_RST_SEQ -- requirements
Module: pulpemu_rst_seq

---
 rtl/pulpemu_rst_seq.sv | 76 +++++++
 tb/tb_pulpemu_rst_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pulpemu_rst_seq.sv
// pulpemu_rst_seq: lock-filtered SoC/cluster reset sequencer with boot-mode latch and abort counter
module pulpemu_rst_seq #(
  parameter int LOCK_FILTER   = 16,
  parameter int SOC_HOLD      = 64,
  parameter int CLUSTER_DELAY = 32,
  parameter int CNT_W         = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_locked_i,
  input  logic       ext_rst_n_i,
  input  logic       bootmode_i,
  input  logic       sw_rst_req_i,
  output logic       soc_rst_n_o,
  output logic       cluster_rst_n_o,
  output logic       bootmode_o,
  output logic       ready_o,
  output logic [2:0] state_o,
  output logic [7:0] rst_cnt_o
);
  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_FILT = 3'd1,
    S_HOLD = 3'd2,
    S_SRUN = 3'd3,
    S_RUN  = 3'd4
  } state_e;
  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soc_q, clu_q, bm_q;
  logic [7:0]       rcnt_q;
  logic             ok, abort;
  assign ok    = clk_locked_i & sync_q[1];
  assign abort = (state_q != S_WAIT) & (~ok | sw_rst_req_i);
  always_comb begin
    state_d = state_q;
    if (abort) state_d = S_WAIT;
    else
      case (state_q)
        S_WAIT:  state_d = ok ? S_FILT : S_WAIT;
        S_FILT:  state_d = (cnt_q == CNT_W'(LOCK_FILTER - 1)) ? S_HOLD : S_FILT;
        S_HOLD:  state_d = (cnt_q == CNT_W'(SOC_HOLD - 1)) ? S_SRUN : S_HOLD;
        S_SRUN:  state_d = (cnt_q == CNT_W'(CLUSTER_DELAY - 1)) ? S_RUN : S_SRUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_WAIT;
      endcase
    // the counter only times the three finite phases, so it stays parked elsewhere
    cnt_d = (state_d != state_q || state_q == S_WAIT || state_q == S_RUN) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= S_WAIT;
      cnt_q   <= '0;
      soc_q   <= 1'b0;
      clu_q   <= 1'b0;
      bm_q    <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      sync_q  <= {sync_q[0], ext_rst_n_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      soc_q   <= (state_d == S_SRUN) | (state_d == S_RUN);
      clu_q   <= state_d == S_RUN;
      if (state_q == S_FILT && state_d == S_HOLD) bm_q <= bootmode_i;
      if (abort && (state_q == S_SRUN || state_q == S_RUN) && rcnt_q != 8'hff) rcnt_q <= rcnt_q + 8'd1;
    end
  end
  assign soc_rst_n_o     = soc_q;
  assign cluster_rst_n_o = clu_q;
  assign ready_o         = clu_q;
  assign bootmode_o      = bm_q;
  assign state_o         = state_q;
  assign rst_cnt_o       = rcnt_q;
endmodule

// File: tb/tb_pulpemu_rst_seq.sv
// tb_pulpemu_rst_seq: table vectors, corner sequences and random stimulus against a phase/age model
module tb_pulpemu_rst_seq;
  localparam int LF = 4, SH = 8, CD = 4;
  logic       clk = 1'b0;
  logic       rst, lk, ext, bm, sw;
  logic       soc, clu, bm_o, rdy;
  logic [2:0] state;
  logic [7:0] rcnt;
  int         errors = 0, checks = 0;
  int         m_ph, m_age, m_cnt, m_bm;
  bit         s0, s1;
  int         dur[4] = '{0, LF, SH, CD};

  pulpemu_rst_seq #(.LOCK_FILTER(LF), .SOC_HOLD(SH), .CLUSTER_DELAY(CD), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .clk_locked_i(lk), .ext_rst_n_i(ext), .bootmode_i(bm),
    .sw_rst_req_i(sw), .soc_rst_n_o(soc), .cluster_rst_n_o(clu), .bootmode_o(bm_o),
    .ready_o(rdy), .state_o(state), .rst_cnt_o(rcnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // phases 1..3 last dur[] cycles each; ext passes through two cycles of delay
  task automatic model_update();
    bit ok;
    if (rst) begin
      m_ph = 0; m_age = 0; m_cnt = 0; m_bm = 0; s0 = 0; s1 = 0;
      return;
    end
    ok = lk && s1;
    s1 = s0;
    s0 = ext;
    if (m_ph != 0 && (!ok || sw)) begin
      if (m_ph >= 3 && m_cnt < 255) m_cnt++;
      m_ph = 0; m_age = 0;
    end else if (m_ph == 0) begin
      if (ok) begin m_ph = 1; m_age = 0; end
    end else if (m_ph < 4) begin
      m_age++;
      if (m_age == dur[m_ph]) begin
        if (m_ph == 1) m_bm = int'(bm);
        m_ph++; m_age = 0;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("state", state, 8'(m_ph));
    chk("soc_rst_n", soc, 8'(m_ph >= 3));
    chk("cluster_rst_n", clu, 8'(m_ph == 4));
    chk("ready", rdy, 8'(m_ph == 4));
    chk("bootmode", bm_o, 8'(m_bm));
    chk("rst_cnt", rcnt, 8'(m_cnt));
  endtask

  task automatic run_until(input int target, input int lim);
    int n = 0;
    rst = 0; lk = 1; ext = 1; sw = 0;
    while (state !== 3'(target) && n < lim) begin step(); n++; end
    chk("reach_state", state, 8'(target));
  endtask

  typedef struct {
    logic       rst, lk, sw;
    logic [2:0] st;
    logic       soc, rdy, bmo;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[21];

  initial begin
    int n;
    logic [7:0] saved;
    rst = 1; lk = 0; ext = 1; bm = 1; sw = 0;
    for (int i = 0; i < 21; i++) begin
      tbl[i].rst = i == 0;
      tbl[i].lk  = i >= 3;
      tbl[i].sw  = i == 20;
      tbl[i].st  = i < 3 ? 3'd0 : i < 7 ? 3'd1 : i < 15 ? 3'd2 : i < 19 ? 3'd3 : i < 20 ? 3'd4 : 3'd0;
      tbl[i].soc = tbl[i].st >= 3'd3;
      tbl[i].rdy = tbl[i].st == 3'd4;
      tbl[i].bmo = i >= 7;
      tbl[i].cnt = i == 20 ? 8'd1 : 8'd0;
    end
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; lk = tbl[i].lk; sw = tbl[i].sw; ext = 1; bm = 1;
      step();
      chk("tbl_state", state, 8'(tbl[i].st));
      chk("tbl_soc", soc, 8'(tbl[i].soc));
      chk("tbl_cluster", clu, 8'(tbl[i].rdy));
      chk("tbl_ready", rdy, 8'(tbl[i].rdy));
      chk("tbl_bootmode", bm_o, 8'(tbl[i].bmo));
      chk("tbl_rst_cnt", rcnt, tbl[i].cnt);
    end
    sw = 0;
    // lock glitch inside FILTER restarts a full filter window
    saved = rcnt;
    step(); step(); step();
    chk("glitch_in_filter", state, 8'd1);
    lk = 0; step();
    chk("glitch_wait", state, 8'd0);
    chk("glitch_cnt", rcnt, saved);
    lk = 1; step();
    chk("glitch_refilter", state, 8'd1);
    n = 0;
    do begin step(); n++; end while (state == 3'd1 && n < 20);
    chk("glitch_filter_len", 8'(n), 8'(LF));
    // pad reset falling in RUN shows up three edges later
    run_until(4, 100);
    saved = rcnt;
    ext = 0; step(); step();
    chk("ext_late_soc", soc, 8'd1);
    step();
    chk("ext_soc", soc, 8'd0);
    chk("ext_ready", rdy, 8'd0);
    chk("ext_state", state, 8'd0);
    chk("ext_cnt", rcnt, saved + 8'd1);
    run_until(2, 100);
    saved = rcnt;
    ext = 0; step(); step(); step();
    chk("ext_hold_state", state, 8'd0);
    chk("ext_hold_cnt", rcnt, saved);
    // abort on the final SOC_RUN cycle beats the move to RUN
    run_until(3, 100);
    step(); step(); step();
    chk("srun_last", state, 8'd3);
    saved = rcnt;
    sw = 1; step(); sw = 0;
    chk("srun_abort_state", state, 8'd0);
    chk("srun_abort_cnt", rcnt, saved + 8'd1);
    // reset in SOC_HOLD with nonzero history
    n = 0;
    while (rcnt < 8'd5 && n < 10) begin run_until(4, 100); sw = 1; step(); sw = 0; n++; end
    chk("cnt_five", rcnt, 8'd5);
    run_until(2, 100);
    chk("hold_bootmode", bm_o, 8'd1);
    rst = 1; step(); rst = 0;
    chk("rst_state", state, 8'd0);
    chk("rst_soc", soc, 8'd0);
    chk("rst_cluster", clu, 8'd0);
    chk("rst_ready", rdy, 8'd0);
    chk("rst_bootmode", bm_o, 8'd0);
    chk("rst_cnt", rcnt, 8'd0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(199) == 0;
      lk  = $urandom_range(29) != 0;
      ext = $urandom_range(59) != 0;
      sw  = $urandom_range(49) == 0;
      bm  = 1'($urandom);
      step();
    end
    rst = 1; step();
    for (int i = 0; i < 300; i++) begin
      run_until(4, 100);
      sw = 1; step(); sw = 0;
    end
    chk("saturate", rcnt, 8'd255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
